// File: rtl/muldiv_pkg.sv
// Shared encodings, defaults and types for the EX-stage multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned XLEN             = 32;
  localparam int unsigned OP_W             = 4;
  localparam int unsigned CNT_W            = 5;
  localparam int unsigned DEF_MULT_CYCLES  = 5;
  localparam int unsigned DEF_DIV_CYCLES   = 10;

  typedef enum logic [OP_W-1:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  // Operation captured at start and held for the whole countdown
  typedef struct packed {
    md_op_e          op;
    logic [XLEN-1:0] rs;
    logic [XLEN-1:0] rt;
  } md_req_t;

  // Ops that occupy the unit for a multi-cycle countdown
  function automatic logic is_md_start(input md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_arith.sv
// Combinational datapath: latched op/operands to a 64-bit {hi,lo} result.
module muldiv_arith
  import muldiv_pkg::*;
(
  input  md_req_t          req_i,
  output logic [2*XLEN-1:0] result_o
);

  logic [2*XLEN-1:0] prod_s;
  logic [2*XLEN-1:0] prod_u;
  logic [XLEN-1:0]   quot_s;
  logic [XLEN-1:0]   rem_s;
  logic [XLEN-1:0]   quot_u;
  logic [XLEN-1:0]   rem_u;
  logic              div_zero;
  logic              div_ovf;

  // Sign-extend to 64 bits so a plain 64-bit product is the signed result
  assign prod_s = {{XLEN{req_i.rs[XLEN-1]}}, req_i.rs} * {{XLEN{req_i.rt[XLEN-1]}}, req_i.rt};
  assign prod_u = {{XLEN{1'b0}}, req_i.rs} * {{XLEN{1'b0}}, req_i.rt};

  assign quot_s = XLEN'($signed(req_i.rs) / $signed(req_i.rt));
  assign rem_s  = XLEN'($signed(req_i.rs) % $signed(req_i.rt));
  assign quot_u = req_i.rs / req_i.rt;
  assign rem_u  = req_i.rs % req_i.rt;

  assign div_zero = (req_i.rt == '0);
  assign div_ovf  = (req_i.rs == 32'h8000_0000) && (req_i.rt == 32'hFFFF_FFFF);

  // Select result; zero divisor and signed overflow are fixed up explicitly
  always_comb begin
    result_o = '0;
    case (req_i.op)
      MD_MULT:  result_o = prod_s;
      MD_MULTU: result_o = prod_u;
      MD_DIV: begin
        if (div_zero)     result_o = {req_i.rs, 32'hFFFF_FFFF};
        else if (div_ovf) result_o = {32'h0000_0000, 32'h8000_0000};
        else              result_o = {rem_s, quot_s};
      end
      MD_DIVU: begin
        if (div_zero) result_o = {req_i.rs, 32'hFFFF_FFFF};
        else          result_o = {rem_u, quot_u};
      end
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer: fixed-latency countdown, HI/LO commit, ID stall request.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = DEF_DIV_CYCLES
)(
  input  logic            clk,
  input  logic            reset,
  input  logic            op_valid,
  input  logic [OP_W-1:0] op,
  input  logic [XLEN-1:0] rs_data,
  input  logic [XLEN-1:0] rt_data,
  input  logic            flush,
  input  logic            id_md_use,
  output logic            busy,
  output logic            stall,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic [XLEN-1:0] mf_data
);

  md_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  md_req_t           req_q, req_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic [2*XLEN-1:0] result;
  md_op_e            op_e;
  logic              accept_c;
  logic              start_c;
  logic              mt_c;

  assign op_e     = md_op_e'(op);
  assign accept_c = op_valid && !flush && (state_q == ST_IDLE);
  assign start_c  = accept_c && is_md_start(op_e);
  assign mt_c     = accept_c && ((op_e == MD_MTHI) || (op_e == MD_MTLO));

  muldiv_arith u_arith (
    .req_i    (req_q),
    .result_o (result)
  );

  // State, counter, operand latches and HI/LO registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      req_q   <= '{op: MD_NONE, rs: '0, rt: '0};
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Next-state: start/mt acceptance in IDLE, countdown and commit in RUN
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start_c) begin
          state_d  = ST_RUN;
          req_d.op = op_e;
          req_d.rs = rs_data;
          req_d.rt = rt_data;
          cnt_d    = ((op_e == MD_MULT) || (op_e == MD_MULTU)) ? CNT_W'(MULT_CYCLES)
                                                               : CNT_W'(DIV_CYCLES);
        end else if (mt_c) begin
          if (op_e == MD_MTHI) hi_d = rs_data;
          else                 lo_d = rs_data;
        end
      end
      ST_RUN: begin
        // Requests arriving here are protocol violations and are dropped
        if (cnt_q == CNT_W'(1)) begin
          hi_d    = result[2*XLEN-1:XLEN];
          lo_d    = result[XLEN-1:0];
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // mfhi/mflo read port for the EX result mux
  always_comb begin
    mf_data = '0;
    case (op_e)
      MD_MFHI: mf_data = hi_q;
      MD_MFLO: mf_data = lo_q;
      default: mf_data = '0;
    endcase
  end

  assign busy  = (state_q == ST_RUN);
  assign stall = id_md_use && (start_c || busy);
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule
